// File: rtl/dkong_dma_pkg.sv
// Shared types and constants for the object-list DMA engine: state encoding,
// CPU register indices and the power-on transfer descriptor.
package dkong_dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRd,
        StWr,
        StDone
    } dma_state_e;

    localparam logic [2:0] RegSrcLo = 3'd0;
    localparam logic [2:0] RegSrcHi = 3'd1;
    localparam logic [2:0] RegDstLo = 3'd2;
    localparam logic [2:0] RegDstHi = 3'd3;
    localparam logic [2:0] RegLenLo = 3'd4;
    localparam logic [2:0] RegLenHi = 3'd5;

    // Default block: 384 bytes from work RAM 0x6900 into object buffer 0x000.
    localparam logic [15:0] SrcDefault = 16'h6900;
    localparam int unsigned DstDefault = 32'h0000_0000;
    localparam int unsigned LenDefault = 32'h0000_017F;

endpackage

// File: rtl/dkong_obj_dma.sv
// Fixed-mode i8257-style channel that copies the sprite list from work RAM into
// the object buffer while holding the CPU bus; advances on the 12 MHz enable.
module dkong_obj_dma
    import dkong_dma_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned CNT_W   = 10
) (
    input  logic             CLK_24M,
    input  logic             I_RST,
    input  logic             CLK_12M_EN,
    input  logic             I_REG_WR,
    input  logic [2:0]       I_REG_A,
    input  logic [7:0]       I_REG_D,
    input  logic             I_DRQ,
    input  logic             I_HLDA,
    input  logic [7:0]       I_SRC_D,
    output logic             O_HOLD,
    output logic [15:0]      O_SRC_A,
    output logic             O_SRC_RDn,
    output logic [CNT_W-1:0] O_DST_A,
    output logic [7:0]       O_DST_D,
    output logic             O_DST_WRn,
    output logic             O_BUSY,
    output logic             O_TC
);

    localparam logic [2:0] WaitInit = 3'(RD_WAIT - 1);

    dma_state_e       state_q;
    logic             drq_q;
    logic [15:0]      src_reg_q, src_reg_d;
    logic [CNT_W-1:0] dst_reg_q, dst_reg_d;
    logic [CNT_W-1:0] len_reg_q, len_reg_d;
    logic [15:0]      src_a_q;
    logic [CNT_W-1:0] dst_a_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       wait_q;
    logic [7:0]       dst_d_q;
    logic             hold_q;
    logic             rdn_q;
    logic             wrn_q;
    logic             busy_q;
    logic             tc_q;
    logic             drq_edge;
    logic             abort;

    assign drq_edge = I_DRQ & ~drq_q;
    assign abort    = ~I_HLDA | ~I_DRQ;

    // Register file next state; computed combinationally so that a write landing
    // on the DRQ edge tick is already visible to the descriptor load.
    always_comb begin
        src_reg_d = src_reg_q;
        dst_reg_d = dst_reg_q;
        len_reg_d = len_reg_q;
        if (CLK_12M_EN && I_REG_WR && (state_q == StIdle)) begin
            case (I_REG_A)
                RegSrcLo: src_reg_d = {src_reg_q[15:8], I_REG_D};
                RegSrcHi: src_reg_d = {I_REG_D, src_reg_q[7:0]};
                RegDstLo: dst_reg_d = {dst_reg_q[CNT_W-1:8], I_REG_D};
                RegDstHi: dst_reg_d = {I_REG_D[CNT_W-9:0], dst_reg_q[7:0]};
                RegLenLo: len_reg_d = {len_reg_q[CNT_W-1:8], I_REG_D};
                RegLenHi: len_reg_d = {I_REG_D[CNT_W-9:0], len_reg_q[7:0]};
                default:  ;
            endcase
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (I_RST) begin
            state_q   <= StIdle;
            drq_q     <= 1'b0;
            src_reg_q <= SrcDefault;
            dst_reg_q <= CNT_W'(DstDefault);
            len_reg_q <= CNT_W'(LenDefault);
            src_a_q   <= '0;
            dst_a_q   <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            dst_d_q   <= '0;
            hold_q    <= 1'b0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            busy_q    <= 1'b0;
            tc_q      <= 1'b0;
        end else if (CLK_12M_EN) begin
            drq_q     <= I_DRQ;
            src_reg_q <= src_reg_d;
            dst_reg_q <= dst_reg_d;
            len_reg_q <= len_reg_d;
            case (state_q)
                StIdle: begin
                    if (drq_edge) begin
                        src_a_q <= src_reg_d;
                        dst_a_q <= dst_reg_d;
                        cnt_q   <= len_reg_d;
                        tc_q    <= 1'b0;
                        hold_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (!I_DRQ) begin
                        hold_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (I_HLDA) begin
                        rdn_q   <= 1'b0;
                        wait_q  <= WaitInit;
                        state_q <= StRd;
                    end
                end
                StRd: begin
                    if (abort) begin
                        hold_q  <= 1'b0;
                        rdn_q   <= 1'b1;
                        wrn_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (wait_q == 3'd0) begin
                        dst_d_q <= I_SRC_D;
                        rdn_q   <= 1'b1;
                        wrn_q   <= 1'b0;
                        state_q <= StWr;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                StWr: begin
                    if (abort) begin
                        hold_q  <= 1'b0;
                        rdn_q   <= 1'b1;
                        wrn_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wrn_q <= 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            // Addresses move only as WR is left, keeping them stable under the strobe.
                            src_a_q <= src_a_q + 16'd1;
                            dst_a_q <= dst_a_q + CNT_W'(1);
                            cnt_q   <= cnt_q - CNT_W'(1);
                            rdn_q   <= 1'b0;
                            wait_q  <= WaitInit;
                            state_q <= StRd;
                        end
                    end
                end
                StDone: begin
                    tc_q    <= 1'b1;
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    hold_q  <= 1'b0;
                    rdn_q   <= 1'b1;
                    wrn_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign O_HOLD    = hold_q;
    assign O_SRC_A   = src_a_q;
    assign O_SRC_RDn = rdn_q;
    assign O_DST_A   = dst_a_q;
    assign O_DST_D   = dst_d_q;
    assign O_DST_WRn = wrn_q;
    assign O_BUSY    = busy_q;
    assign O_TC      = tc_q;

endmodule
